// File: rtl/icache_axi_refill_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_axi_refill_pkg
// Description : Shared definitions for the icache AXI refill engine: refill
//               FSM state encodings, AXI4 read constants and the cache line
//               width used by the way bus.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Contents    : refill_state_t    IDLE / AR / R / DONE
//               BURST_INCR, SIZE_4B, RESP_OKAY
//               WAY_LINE_W, line_width()
// ============================================================================
package icache_axi_refill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DONE = 2'd3
  } refill_state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Way bus line geometry: 8 words of 32 bits.
  localparam int WAY_WORDS  = 8;
  localparam int WAY_WORD_W = 32;
  localparam int WAY_LINE_W = WAY_WORDS * WAY_WORD_W;

  function automatic int line_width(input int words, input int word_w);
    return words * word_w;
  endfunction

endpackage : icache_axi_refill_pkg
`default_nettype wire

// File: rtl/icache_line_assembler.sv
`default_nettype none
// ============================================================================
// Module      : icache_line_assembler
// Description : Beat counter plus line register. Each accepted beat is
//               written into the word slot selected by the counter, which
//               then advances and wraps modulo LINE_WORDS.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : clk, rst_n  clock, asynchronous active-low reset
//               clr         restart the beat counter (line contents kept)
//               we          one beat is accepted this cycle
//               data        beat payload
//               cnt         current word slot
//               line        assembled line, word k at [DATA_W*k +: DATA_W]
// ============================================================================
module icache_line_assembler
  import icache_axi_refill_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 8,
  parameter int CNT_W      = $clog2(LINE_WORDS)
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       clr,
  input  logic                                       we,
  input  logic [DATA_W-1:0]                          data,
  output logic [CNT_W-1:0]                           cnt,
  output logic [line_width(LINE_WORDS, DATA_W)-1:0]  line
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);

  // The line is deliberately not cleared on clr: it must hold the previous
  // refill until the first beat of the next one overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      line <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (we) begin
      line[int'(cnt)*DATA_W +: DATA_W] <= data;
      cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
    end
  end

endmodule : icache_line_assembler
`default_nettype wire

// File: rtl/icache_axi_refill.sv
`default_nettype none
// ============================================================================
// Module      : icache_axi_refill
// Description : AXI4 read-burst refill engine for icache stage 2. Takes one
//               line-miss request, issues a single INCR burst of LINE_WORDS
//               beats from the line base, assembles the line and returns it
//               with a one-cycle rend_o pulse (err_o qualifies it).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : clk, rst_n            clock, asynchronous active-low reset
//               req_i, addr_i         miss request / physical miss address
//               busy_o                high in every state except IDLE
//               rend_o, err_o, line_o line return pulse, error, line data
//               ar*                   AXI read address channel (master)
//               r*                    AXI read data channel (master)
// ============================================================================
module icache_axi_refill
  import icache_axi_refill_pkg::*;
#(
  parameter logic [3:0] AXI_ID     = 4'd0,
  parameter int         ADDR_W     = 32,
  parameter int         DATA_W     = 32,
  parameter int         LINE_WORDS = 8,
  parameter int         OFFSET_W   = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_i,
  input  logic [ADDR_W-1:0]              addr_i,
  output logic                           busy_o,
  output logic                           rend_o,
  output logic [LINE_WORDS*DATA_W-1:0]   line_o,
  output logic                           err_o,
  output logic [3:0]                     arid,
  output logic [ADDR_W-1:0]              araddr,
  output logic [7:0]                     arlen,
  output logic [2:0]                     arsize,
  output logic [1:0]                     arburst,
  output logic                           arvalid,
  input  logic                           arready,
  input  logic [3:0]                     rid,
  input  logic [DATA_W-1:0]              rdata,
  input  logic [1:0]                     rresp,
  input  logic                           rlast,
  input  logic                           rvalid,
  output logic                           rready
);

  localparam int               CNT_W    = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);

  refill_state_t    state;
  refill_state_t    state_nxt;
  logic             start;
  logic             beat;
  logic             beat_err;
  logic             err_flag;
  logic [CNT_W-1:0] cnt;
  logic             unused_offset;

  assign arid    = AXI_ID;
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arsize  = SIZE_4B;
  assign arburst = BURST_INCR;

  // Byte offset within the line is irrelevant: the burst always starts at
  // the line base and stage 2 picks its word from line_o itself.
  assign unused_offset = ^addr_i[OFFSET_W-1:0];

  assign start = (state == ST_IDLE) && req_i;
  assign beat  = (state == ST_R) && rvalid;

  // A last beat on any slot other than the final one means the burst was
  // short, or the counter wrapped because extra beats arrived.
  assign beat_err = (rresp != RESP_OKAY) || (rid != AXI_ID) ||
                    (rlast && (cnt != LAST_CNT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      araddr   <= '0;
      err_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        araddr   <= {addr_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        err_flag <= 1'b0;
      end else if (beat && beat_err) begin
        err_flag <= 1'b1;
      end
    end
  end

  // Handshake outputs depend only on state, so there is no combinational
  // path from arready/rvalid back to arvalid/rready.
  always_comb begin
    state_nxt = state;
    busy_o    = 1'b1;
    arvalid   = 1'b0;
    rready    = 1'b0;
    rend_o    = 1'b0;
    err_o     = 1'b0;
    case (state)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (req_i) state_nxt = ST_AR;
      end
      ST_AR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = ST_R;
      end
      ST_R: begin
        rready = 1'b1;
        if (rvalid && rlast) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        rend_o    = 1'b1;
        err_o     = err_flag;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  icache_line_assembler #(
    .DATA_W     (DATA_W),
    .LINE_WORDS (LINE_WORDS),
    .CNT_W      (CNT_W)
  ) u_line_assembler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .we    (beat),
    .data  (rdata),
    .cnt   (cnt),
    .line  (line_o)
  );

endmodule : icache_axi_refill
`default_nettype wire

// File: tb/tb_icache_axi_refill.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_axi_refill
// Description : Self-checking bench for icache_axi_refill. A table of refill
//               scenarios (address, AR stall, beat gaps, error injection,
//               early rlast, stray request) is played through a small AXI
//               slave driver; reset-in-flight is a hand-written sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_axi_refill;

  logic         clk;
  logic         rst_n;
  logic         req_i;
  logic [31:0]  addr_i;
  logic         busy_o;
  logic         rend_o;
  logic [255:0] line_o;
  logic         err_o;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  int n_tests;
  int n_fail;

  icache_axi_refill dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req_i),
    .addr_i  (addr_i),
    .busy_o  (busy_o),
    .rend_o  (rend_o),
    .line_o  (line_o),
    .err_o   (err_o),
    .arid    (arid),
    .araddr  (araddr),
    .arlen   (arlen),
    .arsize  (arsize),
    .arburst (arburst),
    .arvalid (arvalid),
    .arready (arready),
    .rid     (rid),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_araddr;
    int          ar_stall;   // cycles arready is held low
    logic [7:0]  gap_mask;   // bit k: one idle cycle before beat k
    int          bad_beat;   // beat returning SLVERR, -1 for none
    int          last_beat;  // beat carrying rlast
    int          junk_beat;  // beat during which req_i is pulsed, -1 none
    logic [31:0] base;       // beat k carries base+k
    logic        exp_err;
    int          exp_lat;    // cycles from req (inclusive) to rend_o
    logic [31:0] exp_word2;
    bit          full_chk;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [255:0] exp_line;
    int cyc;
    @(negedge clk);
    req_i  = 1'b1;
    addr_i = v.addr;
    @(posedge clk); #1;
    req_i  = 1'b0;
    addr_i = 32'h0;
    cyc    = 1;
    chk("ar_valid", 256'(arvalid), 256'(1'b1));
    chk("ar_addr",  256'(araddr),  256'(v.exp_araddr));
    chk("ar_busy",  256'(busy_o),  256'(1'b1));
    for (int i = 0; i < v.ar_stall; i++) begin
      arready = 1'b0;
      @(posedge clk); #1;
      cyc++;
      chk("ar_hold_valid",  256'(arvalid), 256'(1'b1));
      chk("ar_hold_addr",   256'(araddr),  256'(v.exp_araddr));
      chk("ar_hold_rready", 256'(rready),  256'(1'b0));
    end
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    cyc++;
    chk("r_rready",  256'(rready),  256'(1'b1));
    chk("r_arvalid", 256'(arvalid), 256'(1'b0));
    for (int k = 0; k <= v.last_beat; k++) begin
      if (v.gap_mask[k]) begin
        rvalid = 1'b0;
        @(posedge clk); #1;
        cyc++;
      end
      rvalid = 1'b1;
      rid    = 4'd0;
      rdata  = v.base + 32'(k);
      rresp  = (k == v.bad_beat) ? 2'b10 : 2'b00;
      rlast  = (k == v.last_beat);
      req_i  = (k == v.junk_beat);
      addr_i = (k == v.junk_beat) ? 32'hDEAD_BEEF : 32'h0;
      @(posedge clk); #1;
      cyc++;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    req_i  = 1'b0;
    addr_i = 32'h0;
    chk("done_rend",    256'(rend_o),       256'(1'b1));
    chk("done_err",     256'(err_o),        256'(v.exp_err));
    chk("done_latency", 256'(cyc),          256'(v.exp_lat));
    chk("done_rready",  256'(rready),       256'(1'b0));
    chk("done_word2",   256'(line_o[95:64]), 256'(v.exp_word2));
    if (v.full_chk) begin
      for (int k = 0; k < 8; k++) exp_line[32*k +: 32] = v.base + 32'(k);
      chk("done_line", line_o, exp_line);
    end
    @(posedge clk); #1;
    chk("idle_rend", 256'(rend_o), 256'(1'b0));
    chk("idle_busy", 256'(busy_o), 256'(1'b0));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    req_i   = 1'b0;
    addr_i  = 32'h0;
    arready = 1'b0;
    rid     = 4'd0;
    rdata   = 32'h0;
    rresp   = 2'b00;
    rlast   = 1'b0;
    rvalid  = 1'b0;

    //           addr          araddr        stl gaps   bad last junk base          err lat word2         full
    vecs[0] = '{32'hBFC0_0014, 32'hBFC0_0000, 0, 8'h00, -1, 7, -1, 32'h1000_0000, 1'b0, 10, 32'h1000_0002, 1'b1};
    vecs[1] = '{32'h8000_1234, 32'h8000_1220, 5, 8'h00, -1, 7, -1, 32'h2000_0000, 1'b0, 15, 32'h2000_0002, 1'b1};
    vecs[2] = '{32'hBFC0_0014, 32'hBFC0_0000, 0, 8'h88, -1, 7, -1, 32'h1000_0000, 1'b0, 12, 32'h1000_0002, 1'b1};
    vecs[3] = '{32'h0000_00FF, 32'h0000_00E0, 0, 8'h00,  4, 7, -1, 32'h3000_0000, 1'b1, 10, 32'h3000_0002, 1'b1};
    vecs[4] = '{32'h1234_5678, 32'h1234_5660, 0, 8'h00, -1, 5, -1, 32'h4000_0000, 1'b1,  8, 32'h4000_0002, 1'b0};
    vecs[5] = '{32'hBFC0_0014, 32'hBFC0_0000, 0, 8'h00, -1, 7,  2, 32'h5000_0000, 1'b0, 10, 32'h5000_0002, 1'b1};
    vecs[6] = '{32'hC000_005C, 32'hC000_0040, 0, 8'h00, -1, 7, -1, 32'h6000_0000, 1'b0, 10, 32'h6000_0002, 1'b1};

    #12;
    chk("rst_arvalid", 256'(arvalid), 256'(1'b0));
    chk("rst_rready",  256'(rready),  256'(1'b0));
    chk("rst_araddr",  256'(araddr),  256'(32'h0));
    chk("rst_rend",    256'(rend_o),  256'(1'b0));
    chk("rst_err",     256'(err_o),   256'(1'b0));
    chk("rst_line",    line_o,        256'(0));
    chk("rst_busy",    256'(busy_o),  256'(1'b0));
    chk("const_arid",    256'(arid),    256'(4'd0));
    chk("const_arlen",   256'(arlen),   256'(8'd7));
    chk("const_arsize",  256'(arsize),  256'(3'b010));
    chk("const_arburst", 256'(arburst), 256'(2'b01));
    @(negedge clk);
    rst_n = 1'b1;

    // Consecutive entries are back-to-back: each request is raised in the
    // first IDLE cycle after the previous DONE.
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Asynchronous reset in the middle of a burst, after beat 3.
    @(negedge clk);
    req_i  = 1'b1;
    addr_i = 32'h0000_1000;
    @(posedge clk); #1;
    req_i   = 1'b0;
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rvalid = 1'b1;
      rdata  = 32'h7000_0000 + 32'(k);
      rlast  = 1'b0;
      @(posedge clk); #1;
    end
    rvalid = 1'b0;
    chk("mid_busy_before_rst", 256'(busy_o), 256'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_arvalid", 256'(arvalid), 256'(1'b0));
    chk("arst_rready",  256'(rready),  256'(1'b0));
    chk("arst_rend",    256'(rend_o),  256'(1'b0));
    chk("arst_line",    line_o,        256'(0));
    chk("arst_busy",    256'(busy_o),  256'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_icache_axi_refill
`default_nettype wire
